// File: rtl/merge_pkg.sv
// Shared types and constants for the 4-way round-robin merge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   NUM_PORTS   number of merged input streams
//   PORT_IDX_W  width of a port index / source tag
//   port_idx_t  encoded port index type
//   rr_next     wrapping "k ports after i" helper used by the arbiter search
package merge_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int PORT_IDX_W = 2;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Index k positions after i, wrapping modulo NUM_PORTS (a power of two,
  // so the wrap is just the natural truncation to PORT_IDX_W bits).
  function automatic port_idx_t rr_next(input port_idx_t i, input int unsigned k);
    port_idx_t step;
    step    = port_idx_t'(k);
    rr_next = port_idx_t'(i + step);
  endfunction

endpackage : merge_pkg

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; the last-grant pointer lives in the parent.
// Latency: 0 cycles (pure combinational).
// Backpressure: no grant is issued while en_i is low.
//
// Ports:
//   req_i   per-port request vector
//   last_i  index of the most recently granted port
//   en_i    grant enable (output stage can accept a word)
//   gnt_o   one-hot grant, all-zero when nothing is granted
//   idx_o   encoded index of the winning requester (valid when vld_o=1)
//   vld_o   a grant is issued this cycle
module rr_arbiter4
  import merge_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_idx_t            last_i,
  input  logic                 en_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output port_idx_t            idx_o,
  output logic                 vld_o
);

  logic      found;
  port_idx_t pick;

  // Search starts one past the last winner and wraps; k=NUM_PORTS revisits
  // the last winner itself, so it only wins when it is the sole requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && req_i[rr_next(last_i, k)]) begin
        found = 1'b1;
        pick  = rr_next(last_i, k);
      end
    end
  end

  assign vld_o = found & en_i;
  assign idx_o = pick;
  assign gnt_o = vld_o ? (NUM_PORTS'(1) << pick) : '0;

endmodule : rr_arbiter4

// File: rtl/simple_merge_rr.sv
// Merges four valid/ready streams into one, tagging each word with its source port.
// Latency: 1 cycle from input transfer to dout_valid; one word per cycle sustained.
// Backpressure: a held output (dout_valid & !dout_ready) blocks every input; all readies low in reset.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   dinN, dinN_valid, dinN_ready    input stream N (N = 0..3)
//   dout, dout_addr                 registered merged word and its source port
//   dout_valid, dout_ready          output handshake
module simple_merge_rr
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  din0_valid,
  output logic                  din0_ready,

  input  logic [DATA_WIDTH-1:0] din1,
  input  logic                  din1_valid,
  output logic                  din1_ready,

  input  logic [DATA_WIDTH-1:0] din2,
  input  logic                  din2_valid,
  output logic                  din2_ready,

  input  logic [DATA_WIDTH-1:0] din3,
  input  logic                  din3_valid,
  output logic                  din3_ready,

  output logic [DATA_WIDTH-1:0] dout,
  output logic [PORT_IDX_W-1:0] dout_addr,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  // Output stage and arbitration pointer.
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  port_idx_t             addr_q, addr_d;
  logic                  vld_q, vld_d;
  port_idx_t             last_q, last_d;

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  gnt;
  port_idx_t             gnt_idx;
  logic                  load;
  logic                  can_load;
  logic [DATA_WIDTH-1:0] sel_dat;

  assign req = {din3_valid, din2_valid, din1_valid, din0_valid};

  // Register is free when empty or being drained this cycle, which allows
  // drain and refill on the same edge. Reset suppresses all acceptance so no
  // input word is consumed by an edge that also clears the output.
  assign can_load = !vld_q || dout_ready;

  rr_arbiter4 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .en_i   (can_load & !reset),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .vld_o  (load)
  );

  assign din0_ready = gnt[0];
  assign din1_ready = gnt[1];
  assign din2_ready = gnt[2];
  assign din3_ready = gnt[3];

  always_comb begin
    sel_dat = din0;
    unique case (gnt_idx)
      2'd0: sel_dat = din0;
      2'd1: sel_dat = din1;
      2'd2: sel_dat = din2;
      2'd3: sel_dat = din3;
      default: sel_dat = din0;
    endcase
  end

  // Pointer only advances on an actual transfer; an idle or stalled cycle
  // leaves priority where it was. On a drain with no refill the data and tag
  // keep their stale value, only the valid drops.
  always_comb begin
    dout_d = dout_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (load) begin
      dout_d = sel_dat;
      addr_d = gnt_idx;
      vld_d  = 1'b1;
      last_d = gnt_idx;
    end else if (dout_ready) begin
      vld_d  = 1'b0;
    end
  end

  // Pointer resets to the last port so port 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
      addr_q <= '0;
      vld_q  <= 1'b0;
      last_q <= port_idx_t'(NUM_PORTS - 1);
    end else begin
      dout_q <= dout_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign dout       = dout_q;
  assign dout_addr  = addr_q;
  assign dout_valid = vld_q;

endmodule : simple_merge_rr

// File: tb/tb_simple_merge_rr.sv
module tb_simple_merge_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;
  logic        din0_valid = 1'b0, din1_valid = 1'b0, din2_valid = 1'b0, din3_valid = 1'b0;
  logic        din0_ready, din1_ready, din2_ready, din3_ready;
  logic [31:0] dout;
  logic [1:0]  dout_addr;
  logic        dout_valid;
  logic        dout_ready = 1'b0;

  always #5 clk = ~clk;

  simple_merge_rr #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (rst),
    .din0       (din0),
    .din0_valid (din0_valid),
    .din0_ready (din0_ready),
    .din1       (din1),
    .din1_valid (din1_valid),
    .din1_ready (din1_ready),
    .din2       (din2),
    .din2_valid (din2_valid),
    .din2_ready (din2_ready),
    .din3       (din3),
    .din3_valid (din3_valid),
    .din3_ready (din3_ready),
    .dout       (dout),
    .dout_addr  (dout_addr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  a;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: whether the output register holds a word, and
  // which port was granted last.
  bit   m_vld  = 1'b0;
  int   m_last = 3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // One clock: drive inputs just after the edge, then at the falling edge
  // check readies and output valid against the model and advance the model.
  task automatic cyc(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2, input logic [31:0] d3,
                     input logic rdy, input logic r);
    logic [31:0] d[4];
    logic [3:0]  rdy_v;
    int          g;
    @(posedge clk);
    #1;
    rst = r;
    din0 = d0; din1 = d1; din2 = d2; din3 = d3;
    {din3_valid, din2_valid, din1_valid, din0_valid} = v;
    dout_ready = rdy;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(negedge clk);
    rdy_v = {din3_ready, din2_ready, din1_ready, din0_ready};
    if (r) begin
      chk("ready_in_reset", {28'd0, rdy_v}, 32'd0);
      exp_q.delete();
      m_vld  = 1'b0;
      m_last = 3;
    end else begin
      chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_vld});
      g = -1;
      if (!m_vld || rdy) begin
        for (int k = 1; k <= 4; k++) begin
          if (g < 0 && v[(m_last + k) % 4]) g = (m_last + k) % 4;
        end
      end
      for (int p = 0; p < 4; p++)
        chk($sformatf("din%0d_ready", p), {31'd0, rdy_v[p]}, {31'd0, (p == g)});
      if (g >= 0) begin
        exp_q.push_back('{d: d[g], a: 2'(g)});
        m_last = g;
        m_vld  = 1'b1;
      end else if (rdy) begin
        m_vld = 1'b0;
      end
    end
  endtask

  // Monitor: whenever the DUT presents a word, it must be the oldest
  // outstanding expected word; it is retired when the sink accepts it.
  always @(negedge clk) begin
    if (!rst && dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dout", dout, 32'hxxxx_xxxx);
      end else begin
        chk("dout", dout, exp_q[0].d);
        chk("dout_addr", {30'd0, dout_addr}, {30'd0, exp_q[0].a});
        if (dout_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset with all valids high.
    cyc(4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1, 1'b1);
    cyc(4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1, 1'b1);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_dout_addr", {30'd0, dout_addr}, 32'd0);
    cyc(4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b1, 1'b0);
    chk("first_din0_ready", {31'd0, din0_ready}, 32'd1);
    cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("first_dout", dout, 32'hA0);
    chk("first_dout_addr", {30'd0, dout_addr}, 32'd0);

    // Fairness: all valid, sink always ready, after a fresh reset.
    cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc(4'hF, 32'h10, 32'h11, 32'h12, 32'h13, 1'b1, 1'b0);
      if (i > 0) begin
        chk("rr_dout", dout, 32'h10 + 32'((i - 1) % 4));
        chk("rr_addr", {30'd0, dout_addr}, 32'((i - 1) % 4));
      end
    end

    // Backpressure: hold 0x22 from port 2 while port 3 waits.
    cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    cyc(4'b0100, 32'h0, 32'h0, 32'h22, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1000, 32'h0, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0);
      chk("bp_din3_ready", {31'd0, din3_ready}, 32'd0);
      chk("bp_dout_hold", dout, 32'h22);
    end
    cyc(4'b1000, 32'h0, 32'h0, 32'h0, 32'h33, 1'b1, 1'b0);
    chk("bp_release_ready", {31'd0, din3_ready}, 32'd1);
    cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("bp_next_dout", dout, 32'h33);
    chk("bp_next_addr", {30'd0, dout_addr}, 32'd3);

    // Sparse: port 1 alone, then port 0 alone (wrap search), then drain.
    cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    cyc(4'b0010, 32'h0, 32'h55, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sparse_p1", {31'd0, din1_ready}, 32'd1);
    cyc(4'b0001, 32'h66, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("sparse_p0", {31'd0, din0_ready}, 32'd1);
    cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(4'b0011, 32'h70, 32'h71, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain_valid_low", {31'd0, dout_valid}, 32'd0);
    chk("drain_ptr_kept", {31'd0, din1_ready}, 32'd1);

    // Reset while holding 0x77.
    cyc(4'b0001, 32'h77, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc(4'b0101, 32'h80, 32'h0, 32'h82, 32'h0, 1'b1, 1'b0);
    chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
    chk("midrst_dout", dout, 32'd0);
    chk("midrst_grant0", {31'd0, din0_ready}, 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(4'($urandom), $urandom, $urandom, $urandom, $urandom,
          1'(($urandom % 4) != 0), 1'(($urandom % 300) == 0));
    end

    // Drain everything and confirm nothing is left outstanding.
    for (int i = 0; i < 4; i++) cyc(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("leftover_words", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_simple_merge_rr

// File: doc/simple_merge_rr.md
Name: simple_merge_rr

Overview:
- Reverse direction of the 4-way address router: merges four independent input streams into one output stream.
- Tags each output word with the 2-bit index of its source port.
- Round-robin arbitration with valid/ready handshakes on every port.
- Single registered output stage; sits upstream of any single-consumer sink fed by multiple producers.

Parameters:
- DATA_WIDTH, 32, width of every data word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- din0  input  DATA_WIDTH  port 0 data.
- din0_valid  input  1  port 0 word present.
- din0_ready  output  1  port 0 word accepted this cycle.
- din1, din1_valid, din1_ready: as port 0, for port 1.
- din2, din2_valid, din2_ready: as port 0, for port 2.
- din3, din3_valid, din3_ready: as port 0, for port 3.
- dout  output  DATA_WIDTH  merged data word (registered).
- dout_addr  output  2  source port of dout (registered).
- dout_valid  output  1  dout/dout_addr hold a word.
- dout_ready  input  1  sink accepts dout this cycle.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: dout=0, dout_addr=0, dout_valid=0, last-grant pointer=3, so port 0 has highest priority first.
- Transfers: a transfer occurs on any port when valid&ready are both high at a clk edge.
- Ready rules:
  - can_load = !dout_valid || dout_ready.
  - At most one dinN_ready is high per cycle: the granted port, only when can_load=1 and that port's valid=1.
  - dinN_ready is combinational from the valids, dout_valid and dout_ready.
  - Producers must not make valid depend on ready.
- Arbitration:
  - Search order starts at (last+1) mod 4 and wraps: last=3 → 0,1,2,3; last=1 → 2,3,0,1.
  - The first valid port in that order wins.
  - On a transfer, last ← granted index.
  - If no transfer occurs, last is unchanged.
- Output register:
  - On a load, dout ← din[g], dout_addr ← g, dout_valid ← 1.
  - When dout_valid=1 and dout_ready=0, dout, dout_addr and dout_valid hold stable (no input accepted).
  - Output drained with no valid input: dout_valid ← 0. dout and dout_addr keep their last value (don't-care).
- Simultaneous drain and load: allowed in the same cycle, giving full throughput of one word per cycle.
- Latency: exactly 1 cycle from an input transfer to dout_valid.
- Fairness: with all four valid continuously and dout_ready=1, grants go 0,1,2,3,0,… A port waits at most 3 other grants.
- Reset mid-operation: reset dominates in the same edge. A pending output word is dropped, no input is accepted that cycle (all dinN_ready=0 while reset=1), and the pointer returns to 3.
- Data is never altered, duplicated or dropped outside reset.

Decomposition:
- Shared package (merge_pkg):
  - NUM_PORTS=4.
  - PORT_IDX_W=2.
  - typedef port_idx_t (logic [1:0]).
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], last pointer, enable (can_load).
  - Outputs: one-hot gnt[3:0] and encoded index.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset with all valids high: during reset all dinN_ready=0 and dout_valid=0. In the first cycle after reset, din0_ready=1, and next cycle dout=din0 value (e.g. 0xA0), dout_addr=0.
- All four ports valid, dout_ready=1 for 8 cycles, din_k=0x10+k: dout sequence 0x10,0x11,0x12,0x13,0x10,… with dout_addr 0,1,2,3,0,… and one word per cycle.
- Backpressure: dout holds 0x22 (addr 2) and dout_ready=0 for 3 cycles with port 3 valid. Required: din3_ready=0 for those 3 cycles and dout stable. When dout_ready rises, din3_ready=1 in the same cycle and dout=port-3 word the next cycle.
- Sparse traffic, only port 1 valid (0x55) after last=3: grant port 1. Then only port 0 valid: grant port 0, because the wrap search from 2 reaches 0.
- Drain without refill: dout_valid=1, dout_ready=1, all valids 0 → next cycle dout_valid=0 and the pointer is unchanged.
- Reset asserted while dout_valid=1 holding 0x77: next cycle dout_valid=0 and dout=0. After release, the first grant goes to port 0 when ports 0 and 2 are both valid.
